// File: rtl/partial_term_gen.sv
// partial_term_gen: walks y LSB-first emitting gated x terms and 2^i weights for a downstream accumulator; PTG_EARLY_EXIT_EN stops once the remaining y bits are zero.
module partial_term_gen #(
  parameter int XW = 12,
  parameter int YW = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [XW-1:0] x_in,
  input  logic [YW-1:0] y_in,
  output logic [XW-1:0] one_bit_mult_x,
  output logic [YW-1:0] powercnt,
  output logic          init_result,
  output logic          ldresult,
  output logic          busy,
  output logic          done
);
  localparam int SW = $clog2(YW);
`ifdef PTG_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif
  typedef enum logic [1:0] {IDLE, INIT, STEP, FIN} state_t;
  state_t        state, state_n;
  logic [XW-1:0] x_reg, x_n;
  logic [YW-1:0] y_reg, y_n;
  logic [SW-1:0] step, step_n;
  logic          last, issue_n;
  always_comb begin
    state_n = state;
    x_n     = x_reg;
    y_n     = y_reg;
    step_n  = step;
    last    = (step == SW'(YW - 1)) || (EARLY && (y_reg >> step) == '0);
    case (state)
      IDLE: if (start) begin
        state_n = INIT;
        x_n     = x_in;
        y_n     = y_in;
        step_n  = '0;
      end
      INIT: begin
        state_n = STEP;
        step_n  = '0;
      end
      STEP: begin
        state_n = last ? FIN : STEP;
        step_n  = last ? step : step + SW'(1);
      end
      default: state_n = IDLE;
    endcase
    // with early exit, the first step whose remaining bits are all zero is a silent one
    issue_n = !(EARLY && (y_reg >> step_n) == '0);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      x_reg          <= '0;
      y_reg          <= '0;
      step           <= '0;
      one_bit_mult_x <= '0;
      powercnt       <= '0;
      init_result    <= 1'b0;
      ldresult       <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
    end else begin
      state          <= state_n;
      x_reg          <= x_n;
      y_reg          <= y_n;
      step           <= step_n;
      one_bit_mult_x <= (state_n == STEP && y_reg[step_n]) ? x_reg : '0;
      powercnt       <= (state_n == STEP) ? YW'(1) << step_n : '0;
      init_result    <= state_n == INIT;
      ldresult       <= state_n == STEP && issue_n;
      busy           <= state_n == INIT || state_n == STEP;
      done           <= state_n == FIN;
    end
  end
endmodule

// File: tb/tb_partial_term_gen.sv
// tb_partial_term_gen: randomized and directed check of partial_term_gen against a cycle schedule model and a product accumulator.
module tb_partial_term_gen;
  localparam int XW = 12;
  localparam int YW = 6;
`ifdef PTG_EARLY_EXIT_EN
  localparam bit EE = 1'b1;
`else
  localparam bit EE = 1'b0;
`endif
  logic          clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [XW-1:0] x_in = '0;
  logic [YW-1:0] y_in = '0;
  logic [XW-1:0] one_bit_mult_x;
  logic [YW-1:0] powercnt;
  logic          init_result, ldresult, busy, done;
  partial_term_gen #(.XW(XW), .YW(YW)) dut (
    .clk(clk), .rst(rst), .start(start), .x_in(x_in), .y_in(y_in),
    .one_bit_mult_x(one_bit_mult_x), .powercnt(powercnt), .init_result(init_result),
    .ldresult(ldresult), .busy(busy), .done(done)
  );
  always #5 clk = ~clk;
  typedef struct packed {
    logic          init, busy, ld, done;
    logic [XW-1:0] term;
    logic [YW-1:0] pw;
  } exp_t;
  exp_t          q[$];
  exp_t          e;
  logic [XW-1:0] exp_prod = '0, acc = '0, last_sum = '0;
  int            ld_cnt = 0, last_ld = 0;
  int            n_chk = 0, n_fail = 0;
  task automatic chk(input string name, input longint act, input longint req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask
  task automatic build(input logic [XW-1:0] x, input logic [YW-1:0] y);
    int k;
    k = YW;
    if (EE) begin
      k = 0;
      for (int i = 0; i < YW; i++) if (y[i]) k = i + 1;
    end
    q.delete();
    q.push_back('{1'b1, 1'b1, 1'b0, 1'b0, '0, '0});
    for (int i = 0; i < k; i++)
      q.push_back('{1'b0, 1'b1, 1'b1, 1'b0, y[i] ? x : '0, YW'(1 << i)});
    if (k < YW) q.push_back('{1'b0, 1'b1, 1'b0, 1'b0, '0, YW'(1 << k)});
    q.push_back('{1'b0, 1'b0, 1'b0, 1'b1, '0, '0});
    exp_prod = XW'(32'(x) * 32'(y));
  endtask
  always @(posedge clk) begin
    if (rst) q.delete();
    else if (q.size() == 0) begin
      if (start) build(x_in, y_in);
    end else void'(q.pop_front());
  end
  always @(negedge clk) begin
    e = (q.size() != 0) ? q[0] : '0;
    chk("init_result", init_result, e.init);
    chk("busy", busy, e.busy);
    chk("ldresult", ldresult, e.ld);
    chk("done", done, e.done);
    chk("one_bit_mult_x", one_bit_mult_x, e.term);
    chk("powercnt", powercnt, e.pw);
    if (init_result) begin
      acc = '0;
      ld_cnt = 0;
    end
    if (ldresult) begin
      acc = XW'(32'(acc) + 32'(one_bit_mult_x) * 32'(powercnt));
      ld_cnt++;
    end
    if (done) begin
      chk("product", acc, exp_prod);
      last_sum = acc;
      last_ld = ld_cnt;
    end
  end
  task automatic run_op(input logic [XW-1:0] x, input logic [YW-1:0] y, input int lat,
                        input int sum, input int lds, input string nm);
    int cnt;
    @(negedge clk);
    start = 1'b1; x_in = x; y_in = y;
    @(negedge clk);
    start = 1'b0; x_in = XW'($urandom); y_in = YW'($urandom);
    cnt = 1;
    while (!done && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    #1;
    chk({nm, "_latency"}, cnt, lat);
    chk({nm, "_sum"}, last_sum, sum);
    chk({nm, "_ld_pulses"}, last_ld, lds);
  endtask
  initial begin
    int cnt, first_done, first_init;
    repeat (2) @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_powercnt", powercnt, 0);
    rst = 1'b0;
    run_op(12'd5, 6'd3, EE ? 5 : 8, 15, EE ? 2 : 6, "x5y3");
    run_op(12'd100, 6'd63, 8, 2204, 6, "x100y63");
    run_op(12'd4095, 6'd0, EE ? 3 : 8, 0, EE ? 0 : 6, "y0");
    run_op(12'd9, 6'd1, EE ? 4 : 8, 9, EE ? 1 : 6, "y1");
    @(negedge clk);
    start = 1'b1; x_in = 12'd7; y_in = 6'd5;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_ldresult", ldresult, 0);
    chk("abort_term", one_bit_mult_x, 0);
    repeat (10) @(negedge clk);
    run_op(12'd7, 6'd5, EE ? 6 : 8, 35, EE ? 3 : 6, "after_abort");
    @(negedge clk);
    start = 1'b1; x_in = 12'd3; y_in = 6'd2;
    cnt = 0; first_done = 0; first_init = 0;
    repeat (20) begin
      @(negedge clk);
      cnt++;
      if (cnt == 2) x_in = 12'd9;
      if (cnt == 3) chk("held_step1_term", one_bit_mult_x, 3);
      if (done && first_done == 0) first_done = cnt;
      if (init_result && cnt > 1 && first_init == 0) first_init = cnt;
    end
    start = 1'b0;
    chk("held_first_done", first_done, EE ? 5 : 8);
    chk("held_next_init", first_init, EE ? 7 : 10);
    repeat (20) @(negedge clk);
    repeat (800) begin
      @(negedge clk);
      rst = $urandom_range(0, 99) < 2;
      start = $urandom_range(0, 3) == 0;
      x_in = XW'($urandom);
      y_in = $urandom_range(0, 1) ? YW'($urandom) : YW'($urandom_range(0, 3));
    end
    rst = 1'b0;
    start = 1'b0;
    repeat (20) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/partial_term_gen.md
Name: partial_term_gen

Overview:
- Sequencer directly upstream of the temp_result accumulator.
- Latches a multiplicand x and a multiplier y, then walks y LSB-first, one bit per clock. For each bit it presents:
  - a gated partial term (x if the bit is 1, else 0), and
  - the bit's binary weight (powercnt = 2^i).
- Drives the accumulator's init_result and ldresult strobes, so the downstream sum of term*weight equals x*y modulo 2^XW.
- Provides a start/busy/done handshake to the top-level controller.

Parameters:
- XW, 12, width of x and of the one_bit_mult_x term (matches accumulator width).
- YW, 6, width of y; also the width of powercnt; number of steps per operation.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request a new operation; sampled only in IDLE
- x_in  input  XW  multiplicand; latched on accepted start
- y_in  input  YW  multiplier; latched on accepted start
- one_bit_mult_x  output  XW  current partial term: x_reg if the current y bit is 1, else 0
- powercnt  output  YW  weight of the current bit, 1 << step
- init_result  output  1  one-cycle pulse that clears the downstream accumulator
- ldresult  output  1  downstream accumulate strobe, valid with one_bit_mult_x/powercnt
- busy  output  1  high from the cycle after start is accepted until done
- done  output  1  one-cycle pulse after the last term has been issued

Behaviour:
- Reset: synchronous on rising clk when rst=1. State=IDLE; x_reg=0, y_reg=0, step=0. All outputs 0: one_bit_mult_x, powercnt, init_result, ldresult, busy, done. rst overrides every other input, including mid-operation; an aborted operation emits no done.
- All outputs are registered.
- States: IDLE, INIT, STEP, FIN.
- IDLE
  - start=1: latch x_in->x_reg, y_in->y_reg, step=0, go to INIT.
  - start=0: stay.
  - Outputs low.
- INIT (1 cycle)
  - init_result=1, busy=1, ldresult=0. Go to STEP.
- STEP (YW cycles, step = 0..YW-1)
  - ldresult=1, busy=1, powercnt = 1<<step.
  - one_bit_mult_x = y_reg[step] ? x_reg : 0.
  - step increments each cycle. After step=YW-1, go to FIN.
  - ldresult is high even when the term is 0; zero terms are issued, not skipped (default build).
- FIN (1 cycle)
  - done=1, busy=0, ldresult=0, powercnt=0, one_bit_mult_x=0. Go to IDLE.
- Latency: start accepted at edge N; init_result high in cycle N+1; terms in cycles N+2..N+1+YW; done in cycle N+2+YW. With defaults, done is 8 cycles after start.
- Back-to-back: start held high during FIN is ignored. A new operation is accepted on the first IDLE cycle, so there is a minimum of one idle cycle between operations.
- start, x_in and y_in are ignored while not in IDLE; changing x_in/y_in mid-operation has no effect.
- Arithmetic: no internal multiply; the term is a pure mux.
  - Downstream product wraps modulo 2^XW; this block does no overflow detection.
  - powercnt never exceeds 2^(YW-1).
- y=0: all YW steps are issued with zero terms; done timing is unchanged.
- Simultaneous events: rst=1 with start=1 -> reset wins; remain in IDLE.

Optional Feature:
- Macro: PTG_EARLY_EXIT_EN
- Defined:
  - In STEP, if the remaining bits y_reg[YW-1:step] are all zero, go directly to FIN that cycle with ldresult=0 (no term issued).
  - y=0 -> done at N+3.
  - y=1 -> one term, then done at N+4.
  - Result is unchanged; latency becomes data-dependent.
- Undefined: fixed YW steps as above.

Test Plan:
- Reset mid-operation: start with x=7, y=5; assert rst during the 3rd STEP cycle -> next cycle all outputs 0, state IDLE, no done pulse. A following start still completes normally.
- x=5, y=3 -> init_result at N+1. Six ldresult cycles with (term, powercnt) = (5,1),(5,2),(0,4),(0,8),(0,16),(0,32). done at N+8; downstream sum = 15.
- x=100, y=63 -> all six terms = 100; weights 1..32; downstream sum = 6300 mod 4096 = 2204 (wrap check).
- y=0, x=4095 -> all terms 0; done at N+8; with PTG_EARLY_EXIT_EN, done at N+3 and zero ldresult pulses.
- start held high continuously with x=3, y=2 -> first op done at N+8; next init_result at N+10. Changing x_in to 9 during busy does not alter terms (term=3 at step 1).
